// File: rtl/alu_pkg.sv
// Shared definitions for the execute/writeback sequencer and its ALU core.
// Optional feature macro: ALU_MUL_EN (enables opcode 9 = MUL).
package alu_pkg;

  // Opcodes, instr[15:12]
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_LI  = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WB
  } state_e;

  // Instruction field bit positions
  localparam int unsigned OP_HI  = 15;
  localparam int unsigned OP_LO  = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 9;
  localparam int unsigned RA_HI  = 8;
  localparam int unsigned RA_LO  = 6;
  localparam int unsigned RB_HI  = 5;
  localparam int unsigned RB_LO  = 3;
  localparam int unsigned IMM_HI = 8;
  localparam int unsigned IMM_LO = 0;

  // Flag bit indices within flags[2:0] = {N, C, Z}
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: (op, a, b, imm) -> (result, {N,C,Z}, illegal).
// Optional feature macro: ALU_MUL_EN (opcode 9 = unsigned multiply, low half).
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [8:0]        imm,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags,
  output logic              illegal
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic [3:0]      sh;
  logic            carry;
`ifdef ALU_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif

  assign sh = b[3:0];

  // Opcode decode, result/carry selection and flag derivation
  always_comb begin
    result  = '0;
    carry   = 1'b0;
    illegal = 1'b0;
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
`ifdef ALU_MUL_EN
    prod    = a * b;
`endif
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: result = a << sh;
      OP_SHR: result = a >> sh;
      OP_LI:  result = {{(DATA_W-9){1'b0}}, imm};
`ifdef ALU_MUL_EN
      OP_MUL: begin
        result = prod[DATA_W-1:0];
        carry  = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: illegal = 1'b1;
    endcase
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_N] = result[DATA_W-1];
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Single-issue fetch/execute/writeback sequencer in front of an 8x16 register file.
// One instruction per 4 cycles: IDLE -> FETCH -> EXEC -> WB -> IDLE.
// Optional feature macro: ALU_MUL_EN (passed through to alu_core).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [SEL_W-1:0]  a_sel,
  output logic [SEL_W-1:0]  b_sel,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic [DATA_W-1:0] w_data,
  output logic [SEL_W-1:0]  w_sel,
  output logic              w_en,
  output logic              done,
  output logic              err,
  output logic [2:0]        flags
);

  state_e            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [SEL_W-1:0]  a_sel_q, a_sel_d, b_sel_q, b_sel_d, w_sel_q, w_sel_d;
  logic [2:0]        flags_q, flags_d;

  logic [DATA_W-1:0] core_result;
  logic [2:0]        core_flags;
  logic              core_illegal;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .op      (instr_q[OP_HI:OP_LO]),
    .a       (op_a_q),
    .b       (op_b_q),
    .imm     (instr_q[IMM_HI:IMM_LO]),
    .result  (core_result),
    .flags   (core_flags),
    .illegal (core_illegal)
  );

  // Read selects are loaded on accept so they are already valid throughout FETCH
  // and then simply hold; w_en/done/err are decoded from the current state.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    w_data_d    = w_data_q;
    a_sel_d     = a_sel_q;
    b_sel_d     = b_sel_q;
    w_sel_d     = w_sel_q;
    flags_d     = flags_q;
    instr_ready = 1'b0;
    w_en        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          a_sel_d = SEL_W'(instr[RA_HI:RA_LO]);
          b_sel_d = SEL_W'(instr[RB_HI:RB_LO]);
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        op_a_d  = a_data;
        op_b_d  = b_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (core_illegal) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          w_data_d = core_result;
          w_sel_d  = SEL_W'(instr_q[RD_HI:RD_LO]);
          flags_d  = core_flags;
          state_d  = ST_WB;
        end
      end
      ST_WB: begin
        w_en    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      w_data_q <= '0;
      a_sel_q  <= '0;
      b_sel_q  <= '0;
      w_sel_q  <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      w_data_q <= w_data_d;
      a_sel_q  <= a_sel_d;
      b_sel_q  <= b_sel_d;
      w_sel_q  <= w_sel_d;
      flags_q  <= flags_d;
    end
  end

  assign a_sel  = a_sel_q;
  assign b_sel  = b_sel_q;
  assign w_data = w_data_q;
  assign w_sel  = w_sel_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, multi-cycle sequences and
// random instructions checked against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  a_sel, b_sel, w_sel;
  logic [15:0] a_data, b_data, w_data;
  logic        w_en, done, err;
  logic [2:0]  flags;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(.DATA_W(16), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .a_sel(a_sel), .b_sel(b_sel), .a_data(a_data), .b_data(b_data),
    .w_data(w_data), .w_sel(w_sel), .w_en(w_en), .done(done), .err(err), .flags(flags)
  );

  always #5 clk = ~clk;

  // Register file fixture
  logic [15:0] rf [8];
  logic        rf_init;
  assign a_data = rf[a_sel];
  assign b_data = rf[b_sel];
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0;
    end else if (w_en) begin
      rf[w_sel] <= w_data;
    end
  end

  // Model state
  longint unsigned mdl [8];
  logic [2:0]      mdl_flags;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic void ref_alu(input int unsigned op, input longint unsigned a,
                                  input longint unsigned b, input int unsigned imm,
                                  output longint unsigned res, output bit c, output bit legal);
    longint unsigned full;
    int unsigned sh;
    legal = 1'b1;
    c     = 1'b0;
    full  = 0;
    sh    = int'(b % 16);
    case (op)
      0: begin full = a + b; c = (full >= 65536); end
      1: begin full = a + 65536 - b; c = (a < b); end
      2: full = a & b;
      3: full = a | b;
      4: full = a ^ b;
      5: full = 65535 - a;
      6: full = a * (64'd1 << sh);
      7: full = a / (64'd1 << sh);
      8: full = imm;
`ifdef ALU_MUL_EN
      9: begin full = a * b; c = (full >= 65536); end
`endif
      default: legal = 1'b0;
    endcase
    res = full % 65536;
  endfunction

  task automatic run_instr(input logic [15:0] ins, output logic g_err, output logic g_wen,
                           output logic g_done, output logic [15:0] g_wd,
                           output logic [2:0] g_ws, output logic [2:0] g_fl);
    int n = 0;
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 16), 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("fetch_ready", 32'(instr_ready), 32'd0);
    chk("fetch_a_sel", 32'(a_sel), 32'(ins[8:6]));
    chk("fetch_b_sel", 32'(b_sel), 32'(ins[5:3]));
    @(posedge clk); #1;
    g_err = err;
    chk("exec_wen", 32'(w_en), 32'd0);
    @(posedge clk); #1;
    g_wen  = w_en;
    g_done = done;
    g_wd   = w_data;
    g_ws   = w_sel;
    g_fl   = flags;
    @(posedge clk); #1;
    chk("idle_ready", 32'(instr_ready), 32'd1);
  endtask

  task automatic do_check(input string tag, input logic [15:0] ins, input logic e_err,
                          input logic [15:0] e_wd, input logic [2:0] e_fl);
    logic g_err, g_wen, g_done;
    logic [15:0] g_wd;
    logic [2:0] g_ws, g_fl;
    run_instr(ins, g_err, g_wen, g_done, g_wd, g_ws, g_fl);
    chk({tag, "_err"}, 32'(g_err), 32'(e_err));
    chk({tag, "_wen"}, 32'(g_wen), 32'(!e_err));
    chk({tag, "_done"}, 32'(g_done), 32'(!e_err));
    if (!e_err) begin
      chk({tag, "_wdata"}, 32'(g_wd), 32'(e_wd));
      chk({tag, "_wsel"}, 32'(g_ws), 32'(ins[11:9]));
    end
    chk({tag, "_flags"}, 32'(g_fl), 32'(e_fl));
  endtask

  typedef struct {
    logic [15:0] ins;
    logic        e_err;
    logic [15:0] e_wd;
    logic [2:0]  e_fl;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [11];
    int acc [3];
    int k, nrdy, cyc;
    logic [15:0] seq [3];

    // Directed vectors: {instr, err, w_data, {N,C,Z}}
    tbl[0]  = '{16'h82F0, 1'b0, 16'h00F0, 3'b000}; // LI r1,0x0F0
    tbl[1]  = '{16'h8400, 1'b0, 16'h0000, 3'b001}; // LI r2,0
    tbl[2]  = '{16'h5480, 1'b0, 16'hFFFF, 3'b100}; // NOT r2,r2
    tbl[3]  = '{16'h8601, 1'b0, 16'h0001, 3'b000}; // LI r3,1
    tbl[4]  = '{16'h0898, 1'b0, 16'h0000, 3'b011}; // ADD r4,r2,r3
    tbl[5]  = '{16'h1AD0, 1'b0, 16'h0002, 3'b010}; // SUB r5,r3,r2
    tbl[6]  = '{16'h6CD8, 1'b0, 16'h0002, 3'b000}; // SHL r6,r3,r3
    tbl[7]  = '{16'h3F80, 1'b0, 16'h0002, 3'b000}; // OR r7,r6,r0 (reads r6)
    tbl[8]  = '{16'hF000, 1'b1, 16'h0000, 3'b000}; // illegal 0xF
    tbl[9]  = '{16'h8300, 1'b0, 16'h0100, 3'b000}; // LI r1,0x100
`ifdef ALU_MUL_EN
    tbl[10] = '{16'h9448, 1'b0, 16'h0000, 3'b011}; // MUL r2,r1,r1
`else
    tbl[10] = '{16'h9448, 1'b1, 16'h0000, 3'b000}; // opcode 9 illegal
`endif

    rst = 1'b1;
    rf_init = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0;
    for (int i = 0; i < 8; i++) mdl[i] = 0;
    mdl_flags = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_wen", 32'(w_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_sels", 32'({a_sel, b_sel, w_sel}), 32'd0);
    chk("rst_wdata", 32'(w_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rf_init = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_check($sformatf("vec%0d", i), tbl[i].ins, tbl[i].e_err, tbl[i].e_wd, tbl[i].e_fl);
      if (!tbl[i].e_err) begin
        mdl[tbl[i].ins[11:9]] = tbl[i].e_wd;
        mdl_flags = tbl[i].e_fl;
      end
    end
    chk("rf6_readback", 32'(rf[6]), 32'h2);

    // Back-to-back: valid held high across three instructions
    seq[0] = 16'h8205; seq[1] = 16'h8406; seq[2] = 16'h8607;
    k = 0; nrdy = 0; cyc = 0;
    @(negedge clk);
    instr = seq[0];
    instr_valid = 1'b1;
    while (k < 3 && cyc < 40) begin
      if (instr_ready) begin
        acc[k] = cyc;
        k++;
        @(posedge clk); #1;
        if (k < 3) instr = seq[k];
        else instr_valid = 1'b0;
      end else begin
        nrdy++;
      end
      @(negedge clk);
      cyc++;
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", 32'(k), 32'd3);
    if (k == 3) begin
      chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'd4);
      chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'd4);
    end
    chk("b2b_notready", 32'(nrdy), 32'd6);
    repeat (4) @(posedge clk);
    #1;
    mdl[1] = 5; mdl[2] = 6; mdl[3] = 7;
    mdl_flags = 3'b000;
    chk("b2b_r3", 32'(rf[3]), 32'd7);

    // Reset during EXEC: in-flight LI r4,0x55 must not be written
    @(negedge clk);
    instr = 16'h8855;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_wen", 32'(w_en), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_ready", 32'(instr_ready), 32'd1);
    chk("mrst_outs", 32'({a_sel, b_sel, w_sel, flags}), 32'd0);
    chk("mrst_wdata", 32'(w_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_ready_after", 32'(instr_ready), 32'd1);
    chk("mrst_wen_after", 32'(w_en), 32'd0);
    chk("mrst_r4_kept", 32'(rf[4]), 32'(mdl[4]));
    mdl_flags = 3'b000;

    // Random instructions against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [15:0] ins;
      longint unsigned res;
      bit c, legal;
      logic [2:0] e_fl;
      ins = 16'($urandom);
      if (i % 8 == 0) ins[15:12] = 4'd8;
      ref_alu(int'(ins[15:12]), mdl[ins[8:6]], mdl[ins[5:3]], int'(ins[8:0]), res, c, legal);
      if (legal) e_fl = {res >= 32768, c, res == 0};
      else e_fl = mdl_flags;
      do_check($sformatf("rnd%0d", i), ins, !legal, 16'(res), e_fl);
      if (legal) begin
        mdl[ins[11:9]] = res;
        mdl_flags = e_fl;
      end
    end
    for (int r = 0; r < 8; r++) chk($sformatf("final_r%0d", r), 32'(rf[r]), 32'(mdl[r]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
